mmio_io_responder: RTL and testbench

MMIO_IO_RESPONDER -- requirements
Module: mmio_io_responder

---
 rtl/io_map_pkg.sv | 34 +++
 rtl/btn_sync_edge.sv | 45 ++++
 rtl/mmio_io_responder.sv | 119 +++++++++++
 tb/tb_mmio_io_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Address map, button indices and status-word layout shared by the MMIO
// button/mailbox responder and its sub-blocks.
package io_map_pkg;

    localparam logic [31:0] DEF_ADDR_BTNC   = 32'd1000;
    localparam logic [31:0] DEF_ADDR_OUT    = 32'd2000;
    localparam logic [31:0] DEF_ADDR_BTNL   = 32'd3000;
    localparam logic [31:0] DEF_ADDR_BTNR   = 32'd4000;
    localparam logic [31:0] DEF_ADDR_BTNU   = 32'd5000;
    localparam logic [31:0] DEF_ADDR_BTND   = 32'd6000;
    localparam logic [31:0] DEF_ADDR_STATUS = 32'd7000;

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned BTN_C   = 0;
    localparam int unsigned BTN_L   = 1;
    localparam int unsigned BTN_R   = 2;
    localparam int unsigned BTN_U   = 3;
    localparam int unsigned BTN_D   = 4;

    localparam int unsigned STAT_LEVEL_LSB = 0;
    localparam int unsigned STAT_VALID_BIT = 5;
    localparam int unsigned STAT_OVF_BIT   = 6;

    function automatic logic [31:0] status_word(input logic ovf, input logic valid,
                                                input logic [NUM_BTN-1:0] level);
        logic [31:0] w;
        w = '0;
        w[STAT_LEVEL_LSB +: NUM_BTN] = level;
        w[STAT_VALID_BIT]            = valid;
        w[STAT_OVF_BIT]              = ovf;
        return w;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer and rising-edge detector for one raw button input.
// Edges are only reported once the synchronized level has been seen low after reset.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       prev_q, prev_d;
    logic [1:0] warm_q, warm_d;
    logic       armed_q, armed_d;

    always_comb begin
        s1_d    = btn_i;
        s2_d    = s1_q;
        prev_d  = s2_q;
        warm_d  = {warm_q[0], 1'b1};
        // s2_q is meaningful only once the pipeline has refilled after reset.
        armed_d = armed_q | (warm_q[1] & ~s2_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            warm_q  <= warm_d;
            armed_q <= armed_d;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~prev_q & armed_q;

endmodule

// File: rtl/mmio_io_responder.sv
// Memory-mapped responder: sticky button-press registers, a status register and
// a one-entry output mailbox toward a display consumer.
module mmio_io_responder
    import io_map_pkg::*;
#(
    parameter logic [31:0] ADDR_BTNC   = DEF_ADDR_BTNC,
    parameter logic [31:0] ADDR_OUT    = DEF_ADDR_OUT,
    parameter logic [31:0] ADDR_BTNL   = DEF_ADDR_BTNL,
    parameter logic [31:0] ADDR_BTNR   = DEF_ADDR_BTNR,
    parameter logic [31:0] ADDR_BTNU   = DEF_ADDR_BTNU,
    parameter logic [31:0] ADDR_BTND   = DEF_ADDR_BTND,
    parameter logic [31:0] ADDR_STATUS = DEF_ADDR_STATUS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic        wren,
    input  logic        mem_en,
    input  logic [31:0] data,
    input  logic [4:0]  btn_in,
    output logic [31:0] q_io,
    output logic        io_hit,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_sync_edge u_sync (
            .clk_i  (clock),
            .rst_ni (reset),
            .btn_i  (btn_in[i]),
            .level_o(level[i]),
            .rise_o (rise[i])
        );
    end

    logic [NUM_BTN-1:0] sticky_q, sticky_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [31:0]        q_io_q, q_io_d;
    logic               io_hit_q, io_hit_d;

    logic [NUM_BTN-1:0] btn_sel;
    logic               sel_out, sel_status, is_load, is_store;
    logic               store_out, accept, handshake;

    always_comb begin
        btn_sel        = '0;
        btn_sel[BTN_C] = (address_dmem == ADDR_BTNC);
        btn_sel[BTN_L] = (address_dmem == ADDR_BTNL);
        btn_sel[BTN_R] = (address_dmem == ADDR_BTNR);
        btn_sel[BTN_U] = (address_dmem == ADDR_BTNU);
        btn_sel[BTN_D] = (address_dmem == ADDR_BTND);
        sel_out        = (address_dmem == ADDR_OUT);
        sel_status     = (address_dmem == ADDR_STATUS);
        is_load        = mem_en & ~wren;
        is_store       = mem_en & wren;
    end

    always_comb begin
        // A new edge re-sets the bit even if the same cycle's read clears it.
        sticky_d = (sticky_q & ~(is_load ? btn_sel : '0)) | rise;

        handshake = out_valid_q & out_ready;
        store_out = is_store & sel_out;
        accept    = store_out & (~out_valid_q | out_ready);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (handshake) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = data;
        end

        overflow_d = (overflow_q & ~(is_load & sel_status)) | (store_out & ~accept);

        io_hit_d = mem_en & ((|btn_sel) | sel_status | sel_out);
        q_io_d   = '0;
        if (is_load) begin
            if (|btn_sel) begin
                q_io_d = {31'b0, |(btn_sel & sticky_q)};
            end else if (sel_status) begin
                q_io_d = status_word(overflow_q, out_valid_q, level);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sticky_q    <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            q_io_q      <= '0;
            io_hit_q    <= 1'b0;
        end else begin
            sticky_q    <= sticky_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            q_io_q      <= q_io_d;
            io_hit_q    <= io_hit_d;
        end
    end

    assign q_io      = q_io_q;
    assign io_hit    = io_hit_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder: button presses, mailbox flow control,
// status register, reset behaviour and address decode.
module tb_mmio_io_responder;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic        wren;
    logic        mem_en;
    logic [31:0] data;
    logic [4:0]  btn_in;
    logic [31:0] q_io;
    logic        io_hit;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_tests;
    int n_fail;

    mmio_io_responder dut (
        .clock       (clock),
        .reset       (reset),
        .address_dmem(address_dmem),
        .wren        (wren),
        .mem_en      (mem_en),
        .data        (data),
        .btn_in      (btn_in),
        .q_io        (q_io),
        .io_hit      (io_hit),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got hang, need finish)");
        $fatal(1, "watchdog");
    end

    // Each step leaves the bench 1 time unit after a rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_load(input logic [31:0] addr);
        mem_en = 1'b1; wren = 1'b0; address_dmem = addr;
        step(1);
        mem_en = 1'b0; address_dmem = '0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] d);
        mem_en = 1'b1; wren = 1'b1; address_dmem = addr; data = d;
        step(1);
        mem_en = 1'b0; wren = 1'b0; address_dmem = '0; data = '0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({q_io, io_hit, out_data, out_valid} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got q_io=%h io_hit=%b out_data=%h out_valid=%b, need all 0",
                     q_io, io_hit, out_data, out_valid);
        end
        step(2);
        reset = 1'b1;
        step(6);
        do_load(32'd1000);
        n_tests++;
        if (q_io !== 32'd0 || io_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_btnc_clear: got q_io=%h io_hit=%b, need 0 and 1", q_io, io_hit);
        end
    endtask

    task automatic test_press;
        btn_in[1] = 1'b1;
        step(10);
        btn_in[1] = 1'b0;
        step(3);
        do_load(32'd3000);
        n_tests++;
        if (q_io !== 32'd1 || io_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL press_first_read: got q_io=%h io_hit=%b, need 1 and 1", q_io, io_hit);
        end
        do_load(32'd3000);
        n_tests++;
        if (q_io !== 32'd0 || io_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL press_cleared: got q_io=%h io_hit=%b, need 0 and 1", q_io, io_hit);
        end
        step(1);
        n_tests++;
        if (q_io !== 32'd0 || io_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_load: got q_io=%h io_hit=%b, need 0 and 0", q_io, io_hit);
        end
        do_load(32'd4000);
        n_tests++;
        if (q_io !== 32'd0) begin
            n_fail++;
            $display("FAIL other_btn_unset: got q_io=%h, need 0", q_io);
        end
    endtask

    task automatic test_status_level;
        btn_in[2] = 1'b1;
        step(4);
        do_load(32'd7000);
        n_tests++;
        if (q_io !== 32'h0000_0004 || io_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL status_level: got q_io=%h io_hit=%b, need 00000004 and 1", q_io, io_hit);
        end
        btn_in[2] = 1'b0;
        step(4);
        do_load(32'd4000);
    endtask

    task automatic test_mailbox;
        out_ready = 1'b0;
        do_store(32'd2000, 32'h0000_00AB);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_00AB) begin
            n_fail++;
            $display("FAIL mbox_store: got valid=%b data=%h, need 1 and 000000ab", out_valid, out_data);
        end
        do_store(32'd2000, 32'h0000_00CD);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_00AB) begin
            n_fail++;
            $display("FAIL mbox_drop: got valid=%b data=%h, need 1 and 000000ab", out_valid, out_data);
        end
        do_load(32'd7000);
        n_tests++;
        if (q_io !== 32'h0000_0060) begin
            n_fail++;
            $display("FAIL status_overflow: got q_io=%h, need 00000060", q_io);
        end
        do_load(32'd7000);
        n_tests++;
        if (q_io !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL status_ovf_cleared: got q_io=%h, need 00000020", q_io);
        end
        do_load(32'd2000);
        n_tests++;
        if (q_io !== 32'd0 || io_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL load_out_addr: got q_io=%h io_hit=%b, need 0 and 1", q_io, io_hit);
        end
        do_store(32'd7000, 32'hFFFF_FFFF);
        do_load(32'd7000);
        n_tests++;
        if (q_io !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL store_status_ignored: got q_io=%h, need 00000020", q_io);
        end
        out_ready = 1'b1;
        step(1);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mbox_drain: got valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        do_store(32'd2000, 32'd5);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd5) begin
            n_fail++;
            $display("FAIL b2b_first: got valid=%b data=%h, need 1 and 5", out_valid, out_data);
        end
        do_store(32'd2000, 32'd6);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_second: got valid=%b data=%h, need 1 and 6", out_valid, out_data);
        end
        step(1);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_valid_fall: got valid=%b, need 0", out_valid);
        end
        do_load(32'd7000);
        n_tests++;
        if (q_io !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_no_overflow: got q_io=%h, need 00000000", q_io);
        end
    endtask

    task automatic test_set_wins;
        btn_in[0] = 1'b1;
        step(5);
        btn_in[0] = 1'b0;
        step(5);
        // Rise appears two edges after btn_in goes high; the load lands on the third.
        btn_in[0] = 1'b1;
        step(2);
        do_load(32'd1000);
        n_tests++;
        if (q_io !== 32'd1) begin
            n_fail++;
            $display("FAIL set_wins_first: got q_io=%h, need 1", q_io);
        end
        do_load(32'd1000);
        n_tests++;
        if (q_io !== 32'd1) begin
            n_fail++;
            $display("FAIL set_wins_second: got q_io=%h, need 1", q_io);
        end
        do_load(32'd1000);
        n_tests++;
        if (q_io !== 32'd0) begin
            n_fail++;
            $display("FAIL set_wins_third: got q_io=%h, need 0", q_io);
        end
        btn_in[0] = 1'b0;
        step(4);
    endtask

    task automatic test_reset_held;
        btn_in[4] = 1'b1;
        out_ready = 1'b0;
        step(5);
        do_store(32'd2000, 32'h1234_5678);
        mem_en = 1'b1; wren = 1'b0; address_dmem = 32'd7000;
        #3;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({q_io, io_hit, out_data, out_valid} !== 66'd0) begin
            n_fail++;
            $display("FAIL midop_reset: got q_io=%h io_hit=%b out_data=%h out_valid=%b, need all 0",
                     q_io, io_hit, out_data, out_valid);
        end
        mem_en = 1'b0; address_dmem = '0;
        step(2);
        reset = 1'b1;
        out_ready = 1'b1;
        step(6);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_drop_mbox: got valid=%b data=%h, need 0 and 0", out_valid, out_data);
        end
        do_load(32'd6000);
        n_tests++;
        if (q_io !== 32'd0) begin
            n_fail++;
            $display("FAIL held_no_press: got q_io=%h, need 0", q_io);
        end
        btn_in[4] = 1'b0;
        step(4);
        btn_in[4] = 1'b1;
        step(4);
        do_load(32'd6000);
        n_tests++;
        if (q_io !== 32'd1) begin
            n_fail++;
            $display("FAIL repress: got q_io=%h, need 1", q_io);
        end
        btn_in[4] = 1'b0;
        step(4);
    endtask

    task automatic test_non_mmio;
        do_load(32'd7000);
        do_load(32'd1001);
        n_tests++;
        if (q_io !== 32'd0 || io_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL load_1001: got q_io=%h io_hit=%b, need 0 and 0", q_io, io_hit);
        end
        do_load(32'd0);
        n_tests++;
        if (q_io !== 32'd0 || io_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL load_0: got q_io=%h io_hit=%b, need 0 and 0", q_io, io_hit);
        end
        do_load(32'h0001_03E8);
        n_tests++;
        if (io_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL no_alias: got io_hit=%b, need 0", io_hit);
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        address_dmem = '0;
        wren         = 1'b0;
        mem_en       = 1'b0;
        data         = '0;
        btn_in       = '0;
        out_ready    = 1'b0;
        step(1);
        test_reset;
        test_press;
        test_status_level;
        test_mailbox;
        test_back_to_back;
        test_set_wins;
        test_reset_held;
        test_non_mmio;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
